// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2), decode (T3), execute (T4-T6), HALT.
// Optional build macro CS_MEM_WAIT_EN: T1 stalls until mem_rdy is sampled high.
module control_sequencer #(
    parameter int             OPW     = 5,
    parameter logic [OPW-1:0] OP_ADD  = OPW'(3),
    parameter logic [OPW-1:0] OP_SUB  = OPW'(4),
    parameter logic [OPW-1:0] OP_AND  = OPW'(5),
    parameter logic [OPW-1:0] OP_OR   = OPW'(6),
    parameter logic [OPW-1:0] OP_DIV  = OPW'(15),
    parameter logic [OPW-1:0] OP_MUL  = OPW'(16),
    parameter logic [OPW-1:0] OP_NOP  = OPW'(26),
    parameter logic [OPW-1:0] OP_HALT = OPW'(27)
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    ir,
    input  logic           mem_rdy,
    output logic           PCout,
    output logic           PCin,
    output logic           IncPC,
    output logic           MARin,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           ZLowIn,
    output logic           ZHighIn,
    output logic           ZLowOut,
    output logic           ZHighOut,
    output logic           LOin,
    output logic           HIin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic [OPW-1:0] alu_op,
    output logic           illegal,
    output logic           halted
);

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [OPW-1:0] opcode;
    logic           is_alu;
    logic           is_muldiv;

    assign opcode    = ir[31:31-OPW+1];
    assign is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                       (opcode == OP_AND) || (opcode == OP_OR);
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);

`ifdef CS_MEM_WAIT_EN
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ir[31-OPW:0]};
`else
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ir[31-OPW:0], mem_rdy};
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg <= S_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    // Strobes are a pure decode of the current state (plus the opcode from T3 on).
    always_comb begin
        state_next = state_reg;
        PCout      = 1'b0;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        ZLowIn     = 1'b0;
        ZHighIn    = 1'b0;
        ZLowOut    = 1'b0;
        ZHighOut   = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        alu_op     = '0;
        illegal    = 1'b0;
        halted     = 1'b0;

        case (state_reg)
            S_RST: begin
                state_next = S_T0;
            end

            S_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                ZLowIn     = 1'b1;
                state_next = S_T1;
            end

            S_T1: begin
                ZLowOut = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
`ifdef CS_MEM_WAIT_EN
                // Re-latching PC while stalled is harmless: Z is not written here.
                state_next = mem_rdy ? S_T2 : S_T1;
`else
                state_next = S_T2;
`endif
            end

            S_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = S_T3;
            end

            S_T3: begin
                if (opcode == OP_NOP) begin
                    state_next = S_T0;
                end else if (opcode == OP_HALT) begin
                    state_next = S_HALT;
                end else if (is_alu) begin
                    Grb        = 1'b1;
                    Rout       = 1'b1;
                    Yin        = 1'b1;
                    state_next = S_T4;
                end else if (is_muldiv) begin
                    Gra        = 1'b1;
                    Rout       = 1'b1;
                    Yin        = 1'b1;
                    state_next = S_T4;
                end else begin
                    illegal    = 1'b1;
                    state_next = S_T0;
                end
            end

            S_T4: begin
                if (is_alu) begin
                    Grc        = 1'b1;
                    Rout       = 1'b1;
                    ZLowIn     = 1'b1;
                    alu_op     = opcode;
                    state_next = S_T5;
                end else if (is_muldiv) begin
                    Grb        = 1'b1;
                    Rout       = 1'b1;
                    ZLowIn     = 1'b1;
                    ZHighIn    = 1'b1;
                    alu_op     = opcode;
                    state_next = S_T5;
                end else begin
                    // ir is expected to be stable here; recover to fetch if it is not.
                    state_next = S_T0;
                end
            end

            S_T5: begin
                if (is_alu) begin
                    ZLowOut    = 1'b1;
                    Gra        = 1'b1;
                    Rin        = 1'b1;
                    state_next = S_T0;
                end else if (is_muldiv) begin
                    ZLowOut    = 1'b1;
                    LOin       = 1'b1;
                    state_next = S_T6;
                end else begin
                    state_next = S_T0;
                end
            end

            S_T6: begin
                ZHighOut   = 1'b1;
                HIin       = 1'b1;
                state_next = S_T0;
            end

            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end

            default: begin
                state_next = S_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer: fetch/execute strobes per T-step,
// illegal, HALT, reset abort, and the memory-wait option when CS_MEM_WAIT_EN is defined.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    logic        mem_rdy;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  alu_op;
    logic        illegal, halted;

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_rdy(mem_rdy),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .ZLowOut(ZLowOut),
        .ZHighOut(ZHighOut), .LOin(LOin), .HIin(HIin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .illegal(illegal), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observation word: bit0 PCout ... bit19 Rout, bit20 illegal, bit21 halted, [26:22] alu_op.
    logic [26:0] obs;
    assign obs = {alu_op, halted, illegal, Rout, Rin, Grc, Grb, Gra, HIin, LOin,
                  ZHighOut, ZLowOut, ZHighIn, ZLowIn, Yin, IRin, MDRout, MDRin,
                  Read, MARin, IncPC, PCin, PCout};

    localparam logic [26:0] B_PCOUT = 27'd1 << 0,  B_PCIN   = 27'd1 << 1;
    localparam logic [26:0] B_INCPC = 27'd1 << 2,  B_MARIN  = 27'd1 << 3;
    localparam logic [26:0] B_READ  = 27'd1 << 4,  B_MDRIN  = 27'd1 << 5;
    localparam logic [26:0] B_MDROUT= 27'd1 << 6,  B_IRIN   = 27'd1 << 7;
    localparam logic [26:0] B_YIN   = 27'd1 << 8,  B_ZLIN   = 27'd1 << 9;
    localparam logic [26:0] B_ZHIN  = 27'd1 << 10, B_ZLOUT  = 27'd1 << 11;
    localparam logic [26:0] B_ZHOUT = 27'd1 << 12, B_LOIN   = 27'd1 << 13;
    localparam logic [26:0] B_HIIN  = 27'd1 << 14, B_GRA    = 27'd1 << 15;
    localparam logic [26:0] B_GRB   = 27'd1 << 16, B_GRC    = 27'd1 << 17;
    localparam logic [26:0] B_RIN   = 27'd1 << 18, B_ROUT   = 27'd1 << 19;
    localparam logic [26:0] B_ILL   = 27'd1 << 20, B_HALT   = 27'd1 << 21;

    localparam logic [26:0] E_T0  = B_PCOUT | B_MARIN | B_INCPC | B_ZLIN;
    localparam logic [26:0] E_T1  = B_ZLOUT | B_PCIN | B_READ | B_MDRIN;
    localparam logic [26:0] E_T2  = B_MDROUT | B_IRIN;
    localparam logic [26:0] E_T3A = B_GRB | B_ROUT | B_YIN;
    localparam logic [26:0] E_T3M = B_GRA | B_ROUT | B_YIN;
    localparam logic [26:0] E_T5A = B_ZLOUT | B_GRA | B_RIN;
    localparam logic [26:0] E_T5M = B_ZLOUT | B_LOIN;
    localparam logic [26:0] E_T6  = B_ZHOUT | B_HIIN;

    localparam logic [31:0] IR_ADD  = 32'h18000000;
    localparam logic [31:0] IR_SUB  = 32'h20000000;
    localparam logic [31:0] IR_AND  = 32'h28000000;
    localparam logic [31:0] IR_OR   = 32'h30000000;
    localparam logic [31:0] IR_DIV  = 32'h78000000;
    localparam logic [31:0] IR_MUL  = 32'h822B8000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000;
    localparam logic [31:0] IR_OP0  = 32'h00000000;

    typedef struct {
        logic [31:0] v_ir;
        logic        v_rdy;
        logic [26:0] v_exp;
        string       v_name;
    } vec_t;

    vec_t tbl[$];
    int   n_err = 0;
    int   n_chk = 0;

    function automatic logic [26:0] aop(input int op);
        logic [4:0] o;
        o = op[4:0];
        return {o, 22'b0};
    endfunction

    task automatic chk(input string name, input logic [26:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, obs, exp, $time);
        end else begin
            $display("check %-12s obs=%h ok", name, obs);
        end
    endtask

    task automatic step(input logic [31:0] v_ir, input logic v_rdy,
                        input logic [26:0] exp, input string name);
        @(negedge clock);
        ir      = v_ir;
        mem_rdy = v_rdy;
        #1;
        chk(name, exp);
    endtask

    // Release clear just after a rising edge so RST is visible for one whole cycle.
    task automatic reset_release();
        @(posedge clock);
        #1 clear = 1'b1;
        @(negedge clock);
        #1 chk("rst_state", 27'd0);
        @(negedge clock);
        #1 chk("t0_after_rst", E_T0);
    endtask

    task automatic add(input logic [31:0] v_ir, input logic [26:0] exp, input string name);
        vec_t v;
        v.v_ir = v_ir; v.v_rdy = 1'b1; v.v_exp = exp; v.v_name = name;
        tbl.push_back(v);
    endtask

    task automatic add_alu(input logic [31:0] v_ir, input int op, input string name);
        add(v_ir, E_T1, {name, "_t1"});
        add(v_ir, E_T2, {name, "_t2"});
        add(v_ir, E_T3A, {name, "_t3"});
        add(v_ir, B_GRC | B_ROUT | B_ZLIN | aop(op), {name, "_t4"});
        add(v_ir, E_T5A, {name, "_t5"});
        add(v_ir, E_T0, {name, "_next"});
    endtask

    task automatic add_md(input logic [31:0] v_ir, input int op, input string name);
        add(v_ir, E_T1, {name, "_t1"});
        add(v_ir, E_T2, {name, "_t2"});
        add(v_ir, E_T3M, {name, "_t3"});
        add(v_ir, B_GRB | B_ROUT | B_ZLIN | B_ZHIN | aop(op), {name, "_t4"});
        add(v_ir, E_T5M, {name, "_t5"});
        add(v_ir, E_T6, {name, "_t6"});
        add(v_ir, E_T0, {name, "_next"});
    endtask

    task automatic add_short(input logic [31:0] v_ir, input logic [26:0] t3,
                             input logic [26:0] after, input string name);
        add(v_ir, E_T1, {name, "_t1"});
        add(v_ir, E_T2, {name, "_t2"});
        add(v_ir, t3, {name, "_t3"});
        add(v_ir, after, {name, "_next"});
    endtask

    initial begin
        clear   = 1'b0;
        ir      = 32'h0;
        mem_rdy = 1'b0;

        add_alu(IR_ADD, 3, "add");
        add_md(IR_MUL, 16, "mul");
        add_alu(IR_SUB, 4, "sub");
        add_alu(IR_AND, 5, "and");
        add_alu(IR_OR, 6, "or");
        add_md(IR_DIV, 15, "div");
        add_short(IR_NOP, 27'd0, E_T0, "nop");
        add_short(IR_BAD, B_ILL, E_T0, "ill31");
        add_short(IR_OP0, B_ILL, E_T0, "ill0");
        add_short(IR_HALT, 27'd0, B_HALT, "halt");

        repeat (3) begin
            @(negedge clock);
            #1 chk("clear_hold", 27'd0);
        end
        reset_release();

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v_ir, tbl[i].v_rdy, tbl[i].v_exp, tbl[i].v_name);
        end

        // HALT must hold regardless of ir, and leave only through clear.
        for (int i = 0; i < 20; i++) begin
            step(IR_ADD, 1'b1, B_HALT, "halt_hold");
        end
        @(negedge clock);
        #2 clear = 1'b0;
        #1 chk("halt_clear", 27'd0);
        reset_release();

        // Memory wait in T1 followed by an abort during T4 of MUL.
        step(IR_MUL, 1'b0, E_T1, "mw_t1");
`ifdef CS_MEM_WAIT_EN
        step(IR_MUL, 1'b0, E_T1, "mw_wait");
        step(IR_MUL, 1'b0, E_T1, "mw_wait");
        step(IR_MUL, 1'b1, E_T1, "mw_wait");
`endif
        step(IR_MUL, 1'b0, E_T2, "mw_t2");
        step(IR_MUL, 1'b0, E_T3M, "mw_t3");
        step(IR_MUL, 1'b0, B_GRB | B_ROUT | B_ZLIN | B_ZHIN | aop(16), "mw_t4");
        #1 clear = 1'b0;
        #1 chk("abort_now", 27'd0);
        for (int i = 0; i < 3; i++) begin
            step(IR_MUL, 1'b1, 27'd0, "abort_hold");
        end
        reset_release();

        step(IR_NOP, 1'b1, E_T1, "post_t1");
        step(IR_NOP, 1'b1, E_T2, "post_t2");
        step(IR_NOP, 1'b1, 27'd0, "post_t3");
        step(IR_NOP, 1'b1, E_T0, "post_next");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
